fsm: RTL and testbench
======================

FSM -- requirements
Module: fsm

Interface
REQ-001 The block SHALL have no parameters; state encoding is fixed by shared constants.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst  input  1  reset, synchronous and active-high.
REQ-004 scan_in  input  1  serial scan data into the state chain.
REQ-005 scan_enable  input  1  1 = scan shift mode, 0 = functional mode.
REQ-006 inp  input  1  functional serial input bit, sampled every functional cycle.
REQ-007 out  output  1  registered detect flag.
REQ-008 scan_out  output  1  serial scan data out of the state chain; may be left unconnected.

Function
REQ-009 The state register SHALL be 2 bits: S0=2'b00 (idle), S1=2'b01 (seen "1"), S2=2'b10 (seen "10"); 2'b11 is illegal.
REQ-010 Functional mode (scan_enable=0, rst=0), transitions per edge:
- S0: inp=1 -> S1; inp=0 -> S0.
- S1: inp=1 -> S1; inp=0 -> S2.
- S2: inp=1 -> S1 (overlap); inp=0 -> S0.
- 2'b11: -> S0 regardless of inp.
REQ-011 In functional mode, out SHALL be set to 1 on an edge where the current state is S2 and inp=1, and to 0 on every other functional edge, so out pulses for exactly one cycle after each "101", overlaps included.
REQ-012 Detect latency SHALL be one clock: out rises at the edge that samples the final '1' and is observable for the following cycle.
REQ-013 Scan mode (scan_enable=1, rst=0): state SHALL shift each edge as state[1] <= state[0], state[0] <= scan_in; inp is ignored.
REQ-014 scan_out SHALL equal state[1] combinationally in all modes.
REQ-015 out SHALL be forced to 0 on every scan-mode edge.
REQ-016 Scan-loaded values, including 2'b11, SHALL be taken as the current state on the first functional edge after scan_enable drops; no extra settling cycle.
REQ-017 Changing scan_enable mid-sequence SHALL take effect on the next edge with no internal memory of the interrupted sequence beyond the state register.

Reset
REQ-018 When rst=1 at a rising edge, state SHALL become S0 and out SHALL become 0, overriding scan_enable, scan_in and inp.
REQ-019 Reset applied mid-detect or mid-scan SHALL discard progress; detection restarts from S0 on the first edge with rst=0.
REQ-020 No asynchronous reset path SHALL exist; before the first reset edge, outputs are undefined.

Structure
REQ-021 A shared package SHALL hold the state typedef (2-bit enum) and the constants S0, S1, S2.
REQ-022 Next-state logic, output logic and the scan multiplexer SHALL be in one module with separate combinational next-state/next-out logic and one sequential register block.
REQ-023 A scan flip-flop sub-module, scan_dff (mux of functional D and scan_in selected by scan_enable, with synchronous reset), SHALL be instantiated twice to form the chain.

Verification
REQ-024 rst=1 for one edge with scan_enable=1 and scan_in=1 -> state=S0, out=0, scan_out=0.
REQ-025 Scan: scan_enable=1, scan_in=1,0,1 on three edges -> state=01 (S1); scan_out goes 0,1,0. Then functional inp=1,0,1 -> state S1, S2, S1, with out=1 after the third edge.
REQ-026 Functional from S0, inp=1,0,1,0,1 -> out high for one cycle after edge 3 and after edge 5 (overlap); out=0 after all other edges.
REQ-027 Scan in 1,1 -> state=2'b11, scan_out=1; one functional edge with inp=1 -> state=S0, out=0.
REQ-028 In S2, assert rst together with inp=1 -> state=S0, out=0. In S2, assert scan_enable=1 with inp=1 -> shift occurs and out=0.
REQ-029 Functional inp=1,1,0,0,1 from S0 -> out stays 0 throughout; final state S1.

Source files
------------

// File: rtl/fsm_pkg.sv
// Shared state encoding for the "101" sequence detector.
// Latency: n/a (constants only).
// Backpressure: n/a.
package fsm_pkg;

    typedef enum logic [1:0] {
        S0      = 2'b00,  // idle
        S1      = 2'b01,  // seen "1"
        S2      = 2'b10,  // seen "10"
        S_ILLEG = 2'b11   // unreachable functionally, reachable via scan
    } state_t;

endpackage

// File: rtl/fsm_scan_dff.sv
// Scan flip-flop: functional d or scan_in selected by scan_enable, sync reset.
// Latency: 1 cycle.
// Backpressure: none; captures every edge.
module scan_dff (
    input  logic clk,
    input  logic rst,
    input  logic scan_enable,
    input  logic scan_in,
    input  logic d,
    output logic q
);

    always_ff @(posedge clk) begin
        if (rst)
            q <= 1'b0;
        else if (scan_enable)
            q <= scan_in;
        else
            q <= d;
    end

endmodule

// File: rtl/fsm.sv
// Overlapping "101" detector with a 2-bit scannable state chain.
// Latency: out is registered, high the cycle after the final '1' is sampled.
// Backpressure: none; inp is consumed every functional cycle.
module fsm
    import fsm_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic scan_in,
    input  logic scan_enable,
    input  logic inp,
    output logic out,
    output logic scan_out
);

    logic [1:0] state_q;
    logic [1:0] nxt_bits;
    logic       q0;
    logic       q1;
    logic       nxt_out;
    state_t     state;
    state_t     nxt;

    assign state_q  = {q1, q0};
    assign state    = state_t'(state_q);
    assign nxt_bits = nxt;
    assign scan_out = q1;

    always_comb begin
        nxt     = S0;
        nxt_out = 1'b0;
        case (state)
            S0:      nxt = inp ? S1 : S0;
            S1:      nxt = inp ? S1 : S2;
            S2:      nxt = inp ? S1 : S0;
            default: nxt = S0;  // recover from a scanned-in 2'b11
        endcase
        nxt_out = (state == S2) && inp;
    end

    // Chain order: scan_in -> bit0 -> bit1 -> scan_out.
    scan_dff u_bit0 (
        .clk         (clk),
        .rst         (rst),
        .scan_enable (scan_enable),
        .scan_in     (scan_in),
        .d           (nxt_bits[0]),
        .q           (q0)
    );

    scan_dff u_bit1 (
        .clk         (clk),
        .rst         (rst),
        .scan_enable (scan_enable),
        .scan_in     (q0),
        .d           (nxt_bits[1]),
        .q           (q1)
    );

    always_ff @(posedge clk) begin
        if (rst || scan_enable)
            out <= 1'b0;
        else
            out <= nxt_out;
    end

endmodule

// File: tb/tb_fsm.sv
// Directed vector bench for the scannable "101" detector.
module tb_fsm;

    logic clk;
    logic rst;
    logic scan_in;
    logic scan_enable;
    logic inp;
    logic out;
    logic scan_out;

    int total;
    int bad;

    fsm dut (
        .clk         (clk),
        .rst         (rst),
        .scan_in     (scan_in),
        .scan_enable (scan_enable),
        .inp         (inp),
        .out         (out),
        .scan_out    (scan_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic       se;
        logic       si;
        logic       inp;
        logic [1:0] exp_state;
        logic       exp_out;
        logic       exp_so;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [1:0] act, input logic [1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%b want=%b", name, act, exp);
        end
    endtask

    task automatic add(input logic r, input logic se, input logic si, input logic i,
                       input logic [1:0] st, input logic o, input logic so);
        vec_t v;
        v.rst = r; v.se = se; v.si = si; v.inp = i;
        v.exp_state = st; v.exp_out = o; v.exp_so = so;
        vecs.push_back(v);
    endtask

    // Drive away from the edge, sample 1 time unit after it.
    task automatic step(input logic r, input logic se, input logic si, input logic i);
        @(negedge clk);
        rst = r; scan_enable = se; scan_in = si; inp = i;
        @(posedge clk);
        #1;
    endtask

    task automatic expect_all(input string tag, input logic [1:0] st, input logic o, input logic so);
        check({tag, ".state"},    dut.state_q,    st);
        check({tag, ".out"},      {1'b0, out},      {1'b0, o});
        check({tag, ".scan_out"}, {1'b0, scan_out}, {1'b0, so});
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst = 1'b0; scan_enable = 1'b0; scan_in = 1'b0; inp = 1'b0;

        // rst se si inp | state out so
        add(1, 1, 1, 0, 2'b00, 0, 0);  // reset overrides scan
        add(0, 1, 1, 0, 2'b01, 0, 0);  // scan in 1,0,1
        add(0, 1, 0, 0, 2'b10, 0, 1);
        add(0, 1, 1, 0, 2'b01, 0, 0);
        add(0, 0, 0, 1, 2'b01, 0, 0);  // functional 1,0,1 from scanned S1
        add(0, 0, 0, 0, 2'b10, 0, 1);
        add(0, 0, 0, 1, 2'b01, 1, 0);
        add(1, 0, 0, 0, 2'b00, 0, 0);  // overlapping 1,0,1,0,1
        add(0, 0, 0, 1, 2'b01, 0, 0);
        add(0, 0, 0, 0, 2'b10, 0, 1);
        add(0, 0, 0, 1, 2'b01, 1, 0);
        add(0, 0, 0, 0, 2'b10, 0, 1);
        add(0, 0, 0, 1, 2'b01, 1, 0);
        add(0, 1, 1, 0, 2'b11, 0, 1);  // scan to illegal 11
        add(0, 1, 1, 0, 2'b11, 0, 1);
        add(0, 0, 0, 1, 2'b00, 0, 0);  // 11 recovers to S0, no detect
        add(0, 0, 0, 1, 2'b01, 0, 0);  // reach S2 then reset with inp=1
        add(0, 0, 0, 0, 2'b10, 0, 1);
        add(1, 0, 0, 1, 2'b00, 0, 0);
        add(0, 0, 0, 1, 2'b01, 0, 0);  // reach S2 then scan edge with inp=1
        add(0, 0, 0, 0, 2'b10, 0, 1);
        add(0, 1, 0, 1, 2'b00, 0, 0);
        add(1, 0, 0, 0, 2'b00, 0, 0);  // 1,1,0,0,1 never detects
        add(0, 0, 0, 1, 2'b01, 0, 0);
        add(0, 0, 0, 1, 2'b01, 0, 0);
        add(0, 0, 0, 0, 2'b10, 0, 1);
        add(0, 0, 0, 0, 2'b00, 0, 0);
        add(0, 0, 0, 1, 2'b01, 0, 0);
        add(0, 1, 1, 0, 2'b11, 0, 1);  // scan S2 in, detect on first functional edge
        add(0, 1, 0, 0, 2'b10, 0, 1);
        add(0, 0, 0, 1, 2'b01, 1, 0);

        for (int k = 0; k < vecs.size(); k++) begin
            step(vecs[k].rst, vecs[k].se, vecs[k].si, vecs[k].inp);
            expect_all($sformatf("vec%0d", k), vecs[k].exp_state, vecs[k].exp_out, vecs[k].exp_so);
        end

        // Scan edge interrupting "10" leaves no memory: the following '1' must not detect.
        step(1, 0, 0, 0);
        expect_all("int.rst", 2'b00, 0, 0);
        step(0, 0, 0, 1);
        step(0, 0, 0, 0);
        expect_all("int.s2", 2'b10, 0, 1);
        step(0, 1, 0, 1);
        expect_all("int.scan", 2'b00, 0, 0);
        step(0, 0, 0, 1);
        expect_all("int.resume", 2'b01, 0, 0);

        // Scan in S2 then detect, then back-to-back overlap continues.
        step(0, 1, 1, 0);
        step(0, 1, 0, 0);
        expect_all("ovl.load", 2'b10, 0, 1);
        step(0, 0, 0, 1);
        expect_all("ovl.det1", 2'b01, 1, 0);
        step(0, 0, 0, 0);
        expect_all("ovl.mid", 2'b10, 0, 1);
        step(0, 0, 0, 1);
        expect_all("ovl.det2", 2'b01, 1, 0);
        step(0, 0, 0, 1);
        expect_all("ovl.drop", 2'b01, 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
